// File: rtl/dwc_window_gen.sv
// Raster-to-window generator: turns a row-major pixel stream into 3x3 interior
// windows packed {p0 .. p8} for the depthwise PE, one cycle after the pixel.
module dwc_window_gen #(
  parameter int DWIDTH = 8,
  parameter int K_SIZE = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              Frame_Start,
  input  logic [DWIDTH-1:0]                 Pixel_In,
  input  logic                              Pixel_In_Valid,
  output logic [DWIDTH*K_SIZE*K_SIZE-1:0]   Window_Out,
  output logic                              Window_Out_Valid,
  output logic                              Frame_Done
);

  localparam int NP = K_SIZE * K_SIZE;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]        col_q, col_d, pos_col;
  logic [RW-1:0]        row_q, row_d, pos_row;
  logic [DWIDTH-1:0]    win_q [NP];
  logic [DWIDTH-1:0]    win_d [NP];
  logic [DWIDTH*NP-1:0] wout_q, wout_d;
  logic                 wv_q, wv_d;
  logic                 fd_q, fd_d;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
  logic [DWIDTH-1:0]    lb1_q [IMG_W];
  logic [DWIDTH-1:0]    lb2_q [IMG_W];

  always_comb begin
    pos_col = Frame_Start ? '0 : col_q;
    pos_row = Frame_Start ? '0 : row_q;
    col_d   = pos_col;
    row_d   = pos_row;
    win_d   = win_q;
    wout_d  = wout_q;
    wv_d    = 1'b0;
    fd_d    = 1'b0;
    if (Pixel_In_Valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_q[pos_col];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_q[pos_col];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = Pixel_In;
      if (pos_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
      end
      // Columns c-2..c were all shifted in during this row, so c >= 2 never mixes rows.
      if (pos_row >= RW'(K_SIZE - 1) && pos_col >= CW'(K_SIZE - 1)) begin
        wv_d = 1'b1;
        fd_d = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));
        for (int k = 0; k < NP; k++) begin
          wout_d[(NP-k)*DWIDTH-1 -: DWIDTH] = win_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      wout_q <= '0;
      wv_q   <= 1'b0;
      fd_q   <= 1'b0;
      for (int k = 0; k < NP; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wout_q <= wout_d;
      wv_q   <= wv_d;
      fd_q   <= fd_d;
      win_q  <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (Pixel_In_Valid) begin
      lb2_q[pos_col] <= lb1_q[pos_col];
      lb1_q[pos_col] <= Pixel_In;
    end
  end

  assign Window_Out       = wout_q;
  assign Window_Out_Valid = wv_q;
  assign Frame_Done       = fd_q;

endmodule

// File: doc/dwc_window_gen.md
# dwc_window_gen

Raster-to-window generator that sits directly upstream of the depthwise 3x3 PE. It accepts a stream of DWIDTH-bit pixels from one channel plane in row-major order and buffers the last K_SIZE-1 rows in line buffers. For every position where a full K_SIZE x K_SIZE window exists, it emits the window packed in the PE's feature format with a one-cycle valid strobe. Only interior windows are produced: stride 1, no padding.

## Interface
- DWIDTH, 8: pixel width in bits; pixels are raw bits, no sign handling.
- K_SIZE, 3: window edge. Only 3 is supported and verified.
- IMG_W, 32: image width in pixels, >= K_SIZE.
- IMG_H, 32: image height in pixels, >= K_SIZE.
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- Frame_Start  in  1  synchronous pulse that clears the row/column position to (0,0).
- Pixel_In  in  DWIDTH  input pixel.
- Pixel_In_Valid  in  1  Pixel_In is accepted this cycle. There is no backpressure.
- Window_Out  out  DWIDTH*K_SIZE*K_SIZE  packed window, {MSB p0, p1, … p8 LSB}; pk sits at bits [(9-k)*DWIDTH-1 -: DWIDTH].
- Window_Out_Valid  out  1  one-cycle strobe per window.
- Frame_Done  out  1  one-cycle strobe with the last window of a frame.

## Operation
- Position counters: col 0..IMG_W-1 and row 0..IMG_H-1, advanced only on accepted pixels.
  - col wraps to 0 and row increments after col = IMG_W-1.
  - Both counters wrap to (0,0) after (IMG_H-1, IMG_W-1).
- Storage: two line buffers of IMG_W entries hold rows r-1 and r-2, plus a 3x3 shift window.
  - On each accepted pixel, the window shifts left by one column.
  - The new right column is {linebuf2[col], linebuf1[col], Pixel_In}, top to bottom.
  - Line buffers are then updated: linebuf2[col] <= linebuf1[col] and linebuf1[col] <= Pixel_In.
- Window layout: for an accepted pixel at (r,c), pk with k = 3i+j is the pixel at (r-2+i, c-2+j), for i, j in 0..2. p0 is top-left and p8 is the current pixel.
- Emission: a window is emitted only for pixels with r >= 2 and c >= 2, giving (IMG_H-2)*(IMG_W-2) windows per frame.
  - Windows must never mix columns across a row wrap.
  - Line-buffer contents at r < 2 are don't-care, because no window is emitted there.
- Frame_Start:
  - Forces the position to (0,0) before the same cycle's pixel is processed. A pixel accepted in the same cycle is therefore (0,0).
  - Does not clear the line buffers, and drops any partial frame silently.
- Frame_Done is asserted together with the Window_Out_Valid of pixel (IMG_H-1, IMG_W-1).
- Idle behaviour: Window_Out holds its last value while Window_Out_Valid = 0.

## Timing
- Latency: exactly 1 cycle. The pixel accepted at edge N drives Window_Out, Window_Out_Valid and Frame_Done after edge N+1.
- Throughput: one pixel per cycle sustained. Arbitrary gaps in Pixel_In_Valid are allowed.
  - Gaps freeze all state.
  - Window_Out_Valid is 0 during a gap.
- Reset values:
  - Window_Out = 0, Window_Out_Valid = 0, Frame_Done = 0.
  - Position counters = (0,0).
  - Shift window = 0.
  - Line buffers need not be reset.
- Reset mid-frame: outputs clear immediately (asynchronously), and the next accepted pixel after release is (0,0).
- Back-to-back frames: the pixel after (IMG_H-1, IMG_W-1) is (0,0) of the next frame with no dead cycle. The first window of the new frame comes only at (2,2).
- Frame_Start and the last pixel of a frame in the same cycle: Frame_Start wins. The pixel is treated as (0,0) and no window or Frame_Done is emitted for it.

## Test plan
- Ramp frame (IMG_W=4, IMG_H=4): pixels 0..15 streamed continuously.
  - Exactly 4 windows appear, at 1 cycle after pixels 10, 11, 14 and 15.
  - First window: Window_Out = 0x00_01_02_04_05_06_08_09_0A.
  - Last window: Window_Out = 0x05_06_07_09_0A_0B_0D_0E_0F, with Frame_Done = 1.
- Same ramp with a random one-to-three-cycle Pixel_In_Valid gap after every pixel: identical window values, Window_Out_Valid never high during a gap, Window_Out stable during gaps.
- Two back-to-back 4x4 frames, the second with values 16..31: 8 windows total. The first window of frame 2 is 0x10_11_12_14_15_16_18_19_1A, with no carry-over of frame-1 data.
- Frame_Start after 9 pixels of a 4x4 frame, followed by a full ramp 0..15: no window emitted from the aborted frame, and the 4 correct windows afterwards.
- Reset_n asserted for 2 cycles after 11 pixels: all outputs 0 during reset. After release, a full ramp yields the correct 4 windows.
- Default 32x32 frame of random data, checked against a reference model: 900 windows, a single Frame_Done strobe, and every window bit-exact.
